bin2bcd_serial: RTL and testbench



---
 rtl/bin2bcd_serial_pkg.sv | 18 +
 rtl/bin2bcd_serial_bcd_add3.sv | 10 +
 rtl/bin2bcd_serial.sv | 102 ++++++++++
 tb/tb_bin2bcd_serial.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/bin2bcd_serial_pkg.sv
// Shared constants and FSM encoding for the serial binary-to-BCD converter.
// WORDSIZE supplies the default input width unless it is set on the command line.
`ifndef WORDSIZE
`define WORDSIZE 20
`endif

package bin2bcd_serial_pkg;

  localparam int          WORDSIZE   = `WORDSIZE;
  localparam int          NUM_DIGITS = 6;
  localparam logic [31:0] BCD_MAX    = 32'd999999;

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

endpackage

// File: rtl/bin2bcd_serial_bcd_add3.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more so the
// following left shift carries correctly into the next digit.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);

  assign q = (d >= 4'd5) ? d + 4'd3 : d;

endmodule

// File: rtl/bin2bcd_serial.sv
// Serial shift-and-add-3 binary-to-BCD converter, one input bit per clock.
// Define BIN2BCD_SATURATE_EN to show 999999 instead of the wrapped value on overflow.
module bin2bcd_serial
  import bin2bcd_serial_pkg::*;
#(
  parameter int WIDTH = WORDSIZE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  output logic             busy,
  output logic             done,
  output logic             overflow,
  output logic [3:0]       out0,
  output logic [3:0]       out1,
  output logic [3:0]       out2,
  output logic [3:0]       out3,
  output logic [3:0]       out4,
  output logic [3:0]       out5
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int BW = 4 * NUM_DIGITS;

  state_t          state;
  logic [WIDTH-1:0] shift;
  logic [BW-1:0]   bcd;
  logic [BW-1:0]   adj;
  logic [BW-1:0]   bcd_next;
  logic [BW-1:0]   result;
  logic [BW-1:0]   digits;
  logic [CW-1:0]   cnt;
  logic            ovf_next;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d (bcd[4*g +: 4]),
      .q (adj[4*g +: 4])
    );
  end

  // Carries out of the top digit fall off the end, giving in mod 10^6.
  assign bcd_next = {adj[BW-2:0], shift[WIDTH-1]};

`ifdef BIN2BCD_SATURATE_EN
  assign result = ovf_next ? {NUM_DIGITS{4'd9}} : bcd_next;
`else
  assign result = bcd_next;
`endif

  // NOTE: all state uses non-blocking assignments so every register samples
  // pre-edge values; mixing in blocking updates would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shift    <= '0;
      bcd      <= '0;
      cnt      <= '0;
      ovf_next <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      digits   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            shift    <= in;
            bcd      <= '0;
            cnt      <= CW'(WIDTH);
            ovf_next <= (32'(in) > BCD_MAX);
            busy     <= 1'b1;
            state    <= CONV;
          end
        end
        CONV: begin
          bcd   <= bcd_next;
          shift <= {shift[WIDTH-2:0], 1'b0};
          cnt   <= cnt - 1'b1;
          if (cnt == CW'(1)) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b1;
            digits   <= result;
            overflow <= ovf_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out0 = digits[3:0];
  assign out1 = digits[7:4];
  assign out2 = digits[11:8];
  assign out3 = digits[15:12];
  assign out4 = digits[19:16];
  assign out5 = digits[23:20];

endmodule

// File: tb/tb_bin2bcd_serial.sv
// Scoreboard bench for bin2bcd_serial at WIDTH=20: stimulus pushes expected
// digits and done-edge index, a negedge monitor pops and compares on each done.
module tb_bin2bcd_serial;

  localparam int WIDTH = 20;
  localparam int LAT   = 20;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] in = '0;
  logic             busy, done, overflow;
  logic [3:0]       out0, out1, out2, out3, out4, out5;
  logic [23:0]      dig;

  typedef struct {
    logic [23:0] dig;
    logic        ovf;
    int          due;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  bin2bcd_serial #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .in       (in),
    .busy     (busy),
    .done     (done),
    .overflow (overflow),
    .out0     (out0),
    .out1     (out1),
    .out2     (out2),
    .out3     (out3),
    .out4     (out4),
    .out5     (out5)
  );

  assign dig = {out5, out4, out3, out2, out1, out0};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding conversion.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("digits", 32'(dig), 32'(e.dig));
        check("overflow", 32'(overflow), 32'(e.ovf));
        check("latency", 32'(cyc), 32'(e.due));
        check("busy_at_done", 32'(busy), 32'd0);
      end
    end
  end

  // Drive start for one edge; returns the index of the accepting edge.
  task automatic pulse_start(input logic [WIDTH-1:0] v, output int acc);
    start = 1'b1;
    in    = v;
    @(posedge clk);
    #1;
    acc   = cyc;
    start = 1'b0;
    in    = '0;
  endtask

  task automatic convert(input logic [WIDTH-1:0] v, input logic [23:0] d, input logic o);
    int acc;
    pulse_start(v, acc);
    sb.push_back('{dig: d, ovf: o, due: acc + LAT});
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (sb.size() != 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    logic [23:0] ovf_dig;
`ifdef BIN2BCD_SATURATE_EN
    ovf_dig = 24'h999999;
`else
    ovf_dig = 24'h048575;
`endif

    // Reset held with start asserted.
    start = 1'b1;
    in    = 20'd5;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    check("rst_digits", 32'(dig), 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("idle_after_release", 32'(busy), 32'd0);

    // Basic and corner conversions.
    convert(20'd123456, 24'h123456, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("busy_mid", 32'(busy), 32'd1);
    drain("drain_123456");

    convert(20'd0, 24'h000000, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check("digits_hold", 32'(dig), 32'h123456);
    drain("drain_0");

    convert(20'd999999, 24'h999999, 1'b0);
    drain("drain_999999");
    convert(20'd100000, 24'h100000, 1'b0);
    drain("drain_100000");
    convert(20'd1048575, ovf_dig, 1'b1);
    drain("drain_ovf");

    // Start while busy is ignored; start in the done cycle is accepted.
    convert(20'd42, 24'h000042, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    pulse_start(20'd777, acc);
    begin
      int n = 0;
      while (!done && n < 40) begin
        @(negedge clk);
        n++;
      end
      check("done_seen_42", 32'(done), 32'd1);
    end
    convert(20'd555, 24'h000555, 1'b0);
    drain("drain_555");
    repeat (25) @(posedge clk);
    #1;

    // Reset mid-conversion abandons the result.
    pulse_start(20'd654321, acc);
    repeat (9) @(posedge clk);
    #1;
    check("busy_before_abort", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_digits", 32'(dig), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("no_done_after_abort", 32'(busy), 32'd0);
    convert(20'd654321, 24'h654321, 1'b0);
    drain("drain_654321");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
